// File: rtl/sfx_pkg.sv
// Shared types, sizes and the effect note ROM for the sound-effect sequencer.
// Optional feature macro: SFX_NOTE_GAP_EN (adds a silent frame between notes).
package sfx_pkg;

   localparam int NUM_SFX   = 2;
   localparam int MAX_NOTES = 8;
   localparam int DUR_W     = 4;
   localparam int NOTE_W    = $clog2(MAX_NOTES);
   localparam int SFX_W     = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

   localparam logic [3:0] TONE_REST = 4'hF;

   typedef struct packed {
      logic [3:0]       tone;
      logic [DUR_W-1:0] dur;
      logic             last;
   } sfx_note_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP
   } sfx_state_t;

   localparam sfx_note_t NOTE_END = '{
      tone: TONE_REST, dur: '0, last: 1'b1
   };

   localparam sfx_note_t SFX_ROM [NUM_SFX][MAX_NOTES] = '{
      '{ '{4'd2, 4'd3, 1'b0},
         '{4'd5, 4'd3, 1'b1},
         NOTE_END, NOTE_END, NOTE_END,
         NOTE_END, NOTE_END, NOTE_END },
      '{ '{4'd9, 4'd2, 1'b0},
         '{TONE_REST, 4'd1, 1'b0},
         '{4'd7, 4'd4, 1'b1},
         NOTE_END, NOTE_END, NOTE_END,
         NOTE_END, NOTE_END }
   };

   // Lowest-indexed set bit wins.
   function automatic logic [SFX_W-1:0] pick_winner(
      input logic [0:NUM_SFX-1] p
   );
      logic [SFX_W-1:0] r;
      r = '0;
      for (int i = NUM_SFX - 1; i >= 0; i--) begin
         if (p[i]) r = SFX_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Registered note lookup: note <= SFX_ROM[sfx][idx] one clock after address.
// Ports: clk, resetN (async low), sfx, idx in; note out.
module sfx_note_rom
   import sfx_pkg::*;
(
   input  logic              clk,
   input  logic              resetN,
   input  logic [SFX_W-1:0]  sfx,
   input  logic [NOTE_W-1:0] idx,
   output sfx_note_t         note
);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) note <= '0;
      else         note <= SFX_ROM[sfx][idx];
   end

endmodule

// File: rtl/sfx_sequencer.sv
// Turns sound request edges into frame-timed note sequences for the tone decoder.
// Ports: clk, resetN, sound_requests, startOfFrame in; sound_signal,
// enable_sound, busy, active_sfx out. Macro SFX_NOTE_GAP_EN adds inter-note gap.
module sfx_sequencer
   import sfx_pkg::*;
(
   input  logic               clk,
   input  logic               resetN,
   input  logic [0:NUM_SFX-1] sound_requests,
   input  logic               startOfFrame,
   output logic [3:0]         sound_signal,
   output logic               enable_sound,
   output logic               busy,
   output logic [SFX_W-1:0]   active_sfx
);

   sfx_state_t         state;
   logic [0:NUM_SFX-1] req_q;
   logic [0:NUM_SFX-1] pending;
   logic [0:NUM_SFX-1] rise;
   logic [0:NUM_SFX-1] clr;
   logic [NOTE_W-1:0]  note_idx;
   logic [DUR_W-1:0]   frame_cnt;
   logic [DUR_W-1:0]   cur_dur;
   logic               cur_last;
   sfx_note_t          rom_q;

   logic [SFX_W-1:0]   winner;
   logic [SFX_W-1:0]   ld_sfx;
   logic [NOTE_W-1:0]  ld_idx;
   logic [DUR_W-1:0]   dur_eff;
   logic               ld_go;
   logic               preempt;
   logic               note_done;
   logic               note_last;

   assign rise      = sound_requests & ~req_q;
   assign winner    = pick_winner(pending);
   assign busy      = (state != ST_IDLE);
   assign dur_eff   = (cur_dur == '0) ? DUR_W'(1) : cur_dur;
   assign note_last = cur_last ||
                      (note_idx == NOTE_W'(MAX_NOTES - 1));
   assign note_done = (state == ST_PLAY) && startOfFrame &&
                      (frame_cnt == dur_eff - 1'b1);
   // Equal index means a retrigger of the running effect.
   assign preempt   = (state != ST_IDLE) && (|pending) &&
                      (winner <= active_sfx);

   // The ROM is addressed with the upcoming note so its read
   // completes while the FSM sits in LOAD.
   always_comb begin
      ld_go  = 1'b0;
      ld_sfx = active_sfx;
      ld_idx = note_idx;
      clr    = '0;
      if (((state == ST_IDLE) && (|pending)) || preempt) begin
         ld_go       = 1'b1;
         ld_sfx      = winner;
         ld_idx      = '0;
         clr[winner] = 1'b1;
`ifdef SFX_NOTE_GAP_EN
      end else if ((state == ST_GAP) && startOfFrame) begin
         ld_go  = 1'b1;
         ld_idx = note_idx + 1'b1;
`else
      end else if (note_done && !note_last) begin
         ld_go  = 1'b1;
         ld_idx = note_idx + 1'b1;
`endif
      end
   end

   sfx_note_rom u_rom (
      .clk    (clk),
      .resetN (resetN),
      .sfx    (ld_sfx),
      .idx    (ld_idx),
      .note   (rom_q)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= ST_IDLE;
         req_q        <= '0;
         pending      <= '0;
         note_idx     <= '0;
         frame_cnt    <= '0;
         cur_dur      <= '0;
         cur_last     <= 1'b0;
         active_sfx   <= '0;
         sound_signal <= '0;
         enable_sound <= 1'b0;
      end else begin
         req_q   <= sound_requests;
         pending <= (pending & ~clr) | rise;
         if (ld_go) begin
            state      <= ST_LOAD;
            active_sfx <= ld_sfx;
            note_idx   <= ld_idx;
         end else begin
            unique case (state)
               ST_LOAD: begin
                  cur_dur      <= rom_q.dur;
                  cur_last     <= rom_q.last;
                  frame_cnt    <= '0;
                  sound_signal <= rom_q.tone;
                  enable_sound <= (rom_q.tone != TONE_REST);
                  state        <= ST_PLAY;
               end
               ST_PLAY: begin
                  if (note_done) begin
                     enable_sound <= 1'b0;
`ifdef SFX_NOTE_GAP_EN
                     state <= note_last ? ST_IDLE : ST_GAP;
`else
                     state <= ST_IDLE;
`endif
                  end else if (startOfFrame) begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
               ST_GAP:  state <= ST_GAP;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
